// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of uart_tx_fifo: write port, FIFO status and serial line.
// brk exists only when UART_TX_BREAK_EN is defined.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 en;
    logic                 wr;
    logic [DATA_BITS-1:0] din;
`ifdef UART_TX_BREAK_EN
    logic                 brk;
`endif
    logic                 full;
    logic                 empty;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic                 busy;
    logic                 done;
    logic                 tx;

    modport master (
`ifdef UART_TX_BREAK_EN
        output brk,
`endif
        output en,
        output wr,
        output din,
        input  full,
        input  empty,
        input  level,
        input  overflow,
        input  busy,
        input  done,
        input  tx
    );

    modport slave (
`ifdef UART_TX_BREAK_EN
        input  brk,
`endif
        input  en,
        input  wr,
        input  din,
        output full,
        output empty,
        output level,
        output overflow,
        output busy,
        output done,
        output tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, baud divider, parity and stop-bit options.
// Define UART_TX_BREAK_EN to add the brk line-break input.
module uart_tx_fifo #(
    parameter int CLOCK_RATE = 12_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input logic          clk,
    input logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(DIV);
    localparam bit HAS_PAR = (PARITY != 0);
    localparam bit ODD_PAR = (PARITY == 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(DIV - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr;
    logic [AW-1:0]        rdPtr;
    logic [LW-1:0]        levelReg;
    logic [LW-1:0]        levelNext;
    logic                 fullReg;
    logic                 emptyReg;
    logic                 ovfReg;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parBit;
    logic                 txReg;
    logic                 busyReg;
    logic                 doneReg;

    logic                 brkReq;
    logic                 push;
    logic                 pop;
    logic                 bitTick;
    logic                 frameEnd;
    logic                 canStart;
    logic [DATA_BITS-1:0] headWord;

`ifdef UART_TX_BREAK_EN
    assign brkReq = bus.brk;
`else
    assign brkReq = 1'b0;
`endif

    assign push     = bus.wr & ~fullReg;
    assign headWord = mem[rdPtr];
    assign bitTick  = (cnt == CNT_LAST);
    assign frameEnd = (state == STOP) & bitTick & (bitCnt == STOP_LAST);
    assign canStart = bus.en & ~emptyReg & ~brkReq;
    assign pop      = canStart & ((state == IDLE) | frameEnd);

    always_comb begin
        levelNext = levelReg;
        if (push & ~pop) begin
            levelNext = levelReg + LW'(1);
        end else if (pop & ~push) begin
            levelNext = levelReg - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= bus.din;
        end
    end

    // A write into a full FIFO is lost even if a pop frees a slot that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            levelReg <= '0;
            fullReg  <= 1'b0;
            emptyReg <= 1'b1;
            ovfReg   <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (bus.wr & fullReg) begin
                ovfReg <= 1'b1;
            end
            levelReg <= levelNext;
            fullReg  <= (levelNext == LVL_FULL);
            emptyReg <= (levelNext == '0);
        end
    end

    // tx is loaded with the value of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            parBit   <= 1'b0;
            txReg    <= 1'b1;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if ((state == IDLE) || bitTick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            unique case (state)
                IDLE: begin
                    txReg <= ~brkReq;
                    if (pop) begin
                        state    <= START;
                        txReg    <= 1'b0;
                        busyReg  <= 1'b1;
                        bitCnt   <= '0;
                        shiftReg <= headWord;
                        parBit   <= ODD_PAR ? ~^headWord : ^headWord;
                    end
                end
                START: begin
                    if (bitTick) begin
                        state  <= DATA;
                        txReg  <= shiftReg[0];
                        bitCnt <= '0;
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        if (bitCnt == DATA_LAST) begin
                            bitCnt <= '0;
                            if (HAS_PAR) begin
                                state <= PAR;
                                txReg <= parBit;
                            end else begin
                                state <= STOP;
                                txReg <= 1'b1;
                            end
                        end else begin
                            bitCnt   <= bitCnt + 4'd1;
                            shiftReg <= shiftReg >> 1;
                            txReg    <= shiftReg[1];
                        end
                    end
                end
                PAR: begin
                    if (bitTick) begin
                        state  <= STOP;
                        txReg  <= 1'b1;
                        bitCnt <= '0;
                    end
                end
                STOP: begin
                    if ((bitCnt == STOP_LAST) && (cnt == CNT_PRE)) begin
                        doneReg <= 1'b1;
                    end
                    if (bitTick) begin
                        if (bitCnt != STOP_LAST) begin
                            bitCnt <= bitCnt + 4'd1;
                        end else if (pop) begin
                            state    <= START;
                            txReg    <= 1'b0;
                            bitCnt   <= '0;
                            shiftReg <= headWord;
                            parBit   <= ODD_PAR ? ~^headWord : ^headWord;
                        end else begin
                            state   <= IDLE;
                            txReg   <= ~brkReq;
                            busyReg <= 1'b0;
                            bitCnt  <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    txReg   <= 1'b1;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.full     = fullReg;
    assign bus.empty    = emptyReg;
    assign bus.level    = levelReg;
    assign bus.overflow = ovfReg;
    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
    assign bus.tx       = txReg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level model on the 8N1 instance plus
// directed parity, overflow, back-to-back, reset and break vectors.
module tb_uart_tx_fifo;
    localparam int DIV   = 10;
    localparam int DB    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic brkDrv;
    logic started;
    int   checks = 0;
    int   errors = 0;

    uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) ifA ();
    uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) ifB ();
    uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) ifC ();

    uart_tx_fifo #(
        .CLOCK_RATE(100), .BAUD_RATE(10), .DATA_BITS(DB),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));

    uart_tx_fifo #(
        .CLOCK_RATE(100), .BAUD_RATE(10), .DATA_BITS(DB),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

    uart_tx_fifo #(
        .CLOCK_RATE(100), .BAUD_RATE(10), .DATA_BITS(DB),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

`ifdef UART_TX_BREAK_EN
    assign ifA.brk = brkDrv;
    assign ifB.brk = 1'b0;
    assign ifC.brk = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model of DUT A: FIFO as a word queue, line as a queue of per-cycle tx values.
    logic [DB-1:0] mq[$];
    logic          mLine[$];
    logic          mOvf;
    logic          mBrk;
    int            mPre;
    bit            mStart;

    task automatic addFrame(input logic [DB-1:0] w);
        repeat (DIV) mLine.push_back(1'b0);
        for (int b = 0; b < DB; b++) begin
            repeat (DIV) mLine.push_back(w[b]);
        end
        repeat (DIV) mLine.push_back(1'b1);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mLine.delete();
            mOvf = 1'b0;
            mBrk = 1'b0;
        end else begin
            mPre   = mq.size();
            mStart = ifA.en && (mPre > 0) && !brkDrv && (mLine.size() <= 1);
            if (mLine.size() > 0) void'(mLine.pop_front());
            if (mStart) addFrame(mq.pop_front());
            if (ifA.wr) begin
                if (mPre == DEPTH) mOvf = 1'b1;
                else mq.push_back(ifA.din);
            end
            mBrk = brkDrv;
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("A.tx", ifA.tx,
                (mLine.size() > 0) ? mLine[0] : !mBrk);
            chk("A.busy", ifA.busy, mLine.size() > 0);
            chk("A.done", ifA.done, mLine.size() == 1);
            chk("A.level", ifA.level, mq.size());
            chk("A.full", ifA.full, mq.size() == DEPTH);
            chk("A.empty", ifA.empty, mq.size() == 0);
            chk("A.overflow", ifA.overflow, mOvf);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic expA5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int   busyCnt;
    int   doneCnt;

    initial begin
        rst = 1'b1;
        brkDrv = 1'b0;
        started = 1'b0;
        ifA.en = 1'b0; ifA.wr = 1'b0; ifA.din = '0;
        ifB.en = 1'b0; ifB.wr = 1'b0; ifB.din = '0;
        ifC.en = 1'b0; ifC.wr = 1'b0; ifC.din = '0;
        repeat (3) @(negedge clk);
        chk("rst.tx", ifA.tx, 1);
        chk("rst.busy", ifA.busy, 0);
        chk("rst.done", ifA.done, 0);
        chk("rst.overflow", ifA.overflow, 0);
        chk("rst.empty", ifA.empty, 1);
        chk("rst.full", ifA.full, 0);
        chk("rst.level", ifA.level, 0);
        rst = 1'b0;
        started = 1'b1;

        // 0xA5 on 8N1, 0x07 with even and odd parity
        ifA.en = 1'b1; ifB.en = 1'b1; ifC.en = 1'b1;
        @(negedge clk);
        ifA.wr = 1'b1; ifA.din = 8'hA5;
        ifB.wr = 1'b1; ifB.din = 8'h07;
        ifC.wr = 1'b1; ifC.din = 8'h07;
        @(negedge clk);
        ifA.wr = 1'b0; ifB.wr = 1'b0; ifC.wr = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (k <= 100 && (k - 1) % 10 == 5)
                chk($sformatf("a5.bit%0d", (k - 1) / 10), ifA.tx, expA5[(k-1)/10]);
            if (k == 99)  chk("a5.done99", ifA.done, 0);
            if (k == 100) chk("a5.done100", ifA.done, 1);
            if (k == 101) chk("a5.busy101", ifA.busy, 0);
            if (k == 95)  chk("even.par", ifB.tx, 1);
            if (k == 95)  chk("odd.par", ifC.tx, 0);
            if (k == 109) chk("even.done109", ifB.done, 0);
            if (k == 110) chk("even.done110", ifB.done, 1);
            if (k == 110) chk("odd.done110", ifC.done, 1);
        end
        @(negedge clk);
        chk("even.busyEnd", ifB.busy, 0);
        repeat (20) @(negedge clk);

        // two words back-to-back
        ifA.wr = 1'b1; ifA.din = 8'h3C;
        @(negedge clk);
        ifA.din = 8'hC3;
        @(negedge clk);
        ifA.wr = 1'b0;
        busyCnt = 0;
        doneCnt = 0;
        for (int k = 1; k <= 220; k++) begin
            if (ifA.busy) busyCnt++;
            if (ifA.done) doneCnt++;
            if (k == 100) chk("b2b.stop1", ifA.tx, 1);
            if (k == 101) chk("b2b.start2", ifA.tx, 0);
            @(negedge clk);
        end
        chk("b2b.busyCycles", busyCnt, 200);
        chk("b2b.dones", doneCnt, 2);

        // overflow with en low, then drain
        ifA.en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ifA.wr = 1'b1;
            ifA.din = 8'(i * 17 + 3);
            @(negedge clk);
        end
        ifA.wr = 1'b0;
        chk("ovf.full", ifA.full, 1);
        chk("ovf.level", ifA.level, 16);
        chk("ovf.flag", ifA.overflow, 1);
        chk("ovf.busy", ifA.busy, 0);
        ifA.en = 1'b1;
        doneCnt = 0;
        for (int k = 0; k < 1800; k++) begin
            @(negedge clk);
            if (ifA.done) doneCnt++;
        end
        chk("drain.frames", doneCnt, 16);
        chk("drain.level", ifA.level, 0);
        chk("drain.busy", ifA.busy, 0);
        chk("drain.overflow", ifA.overflow, 1);

        // reset mid-frame with 3 words queued
        for (int i = 0; i < 4; i++) begin
            ifA.wr = 1'b1;
            ifA.din = 8'h00;
            @(negedge clk);
        end
        ifA.wr = 1'b0;
        repeat (32) @(negedge clk);
        chk("rstmid.txBefore", ifA.tx, 0);
        chk("rstmid.levelBefore", ifA.level, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid.tx", ifA.tx, 1);
        chk("rstmid.level", ifA.level, 0);
        chk("rstmid.busy", ifA.busy, 0);
        chk("rstmid.overflow", ifA.overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        busyCnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ifA.busy || !ifA.tx) busyCnt++;
        end
        chk("rstmid.quiet", busyCnt, 0);

`ifdef UART_TX_BREAK_EN
        brkDrv = 1'b1;
        ifA.wr = 1'b1; ifA.din = 8'h5A;
        @(negedge clk);
        ifA.wr = 1'b0;
        repeat (10) @(negedge clk);
        chk("brk.tx", ifA.tx, 0);
        chk("brk.busy", ifA.busy, 0);
        chk("brk.level", ifA.level, 1);
        brkDrv = 1'b0;
        @(negedge clk);
        chk("brk.startBusy", ifA.busy, 1);
        chk("brk.startTx", ifA.tx, 0);
        repeat (110) @(negedge clk);
        chk("brk.endBusy", ifA.busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with built-in baud divider and write-side FIFO; the next-generation replacement for the fixed 8-bit, TX-only serial path. Host logic pushes words at system-clock rate. The block serialises them back-to-back with configurable data width, parity and stop bits. It sits between the game/score logic and the board's serial TX pin.

## Interface
- `CLOCK_RATE`, 12_000_000, system clock frequency in Hz
- `BAUD_RATE`, 9600, line rate in bit/s; `DIV = CLOCK_RATE / BAUD_RATE` (integer floor, must be ≥ 2)
- `DATA_BITS`, 8, word width, legal range 5..9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, legal values 1 or 2
- `FIFO_DEPTH`, 16, FIFO entries, power of two ≥ 2
- `clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  allows new frames to start; does not abort a frame in progress
- `wr`  in  1  push `din` into the FIFO
- `din`  in  DATA_BITS  word to send
- `full`  out  1  FIFO holds FIFO_DEPTH words
- `empty`  out  1  FIFO holds 0 words
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky; set when a write is dropped; cleared only by `rst`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of each frame's last stop bit
- `tx`  out  1  serial line, registered, idle high

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `overflow`=0, `empty`=1, `full`=0, `level`=0. The FIFO is emptied, the state is IDLE and the baud counter is 0.
- Write rule:
  - `wr` while not full stores `din` and increments `level`.
  - `wr` while full drops the word and sets `overflow`. This holds even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves `level` unchanged.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE/START.
  - IDLE: when `en`=1 and `empty`=0, pop the head word into the shift register, clear the baud counter and go to START.
  - START: `tx`=0.
  - DATA: `tx` = shift register LSB; shifts right each bit; DATA_BITS bits are sent, LSB first.
  - PARITY: entered only if PARITY≠0. `tx` = XOR of the data bits for even parity, inverted XOR for odd parity.
  - STOP: `tx`=1 for STOP_BITS bit periods.
- At the end of the last stop bit, `done` pulses. If `en`=1 and the FIFO is non-empty, the next word is popped in that same cycle and the FSM goes directly to START with no idle gap. Otherwise it goes to IDLE.
- Deasserting `en` mid-frame completes the current frame; no further frames start.
- Reset mid-frame: `tx` returns high immediately and asynchronously; the queued words are lost.

## Timing
- Baud counter runs 0..DIV-1 while `busy`. The bit boundary is the cycle where the count is DIV-1; the counter then wraps to 0. Every bit period is exactly DIV cycles.
- Start latency: a write into an empty FIFO in cycle N with `en`=1 gives `empty`=0 at N+1. The pop happens at the N+1 edge decision, so `tx`=0 and `busy`=1 from cycle N+2.
- Frame length = DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- `done` is high in the final cycle of the frame. `busy` falls on the next cycle only if no back-to-back frame follows.
- `full`, `empty` and `level` are registered and update the cycle after the write or pop.

## Configuration
- `UART_TX_BREAK_EN` defined:
  - Adds input `brk` (1 bit).
  - While `brk`=1 and the FSM is in IDLE, `tx` is driven 0 (line break) and no frame starts.
  - `brk` asserted mid-frame takes effect only after the frame completes.
- Not defined: the `brk` port is absent and `tx` is high whenever the FSM is in IDLE.

## Test plan
- DIV=10, 8N1, write 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; `done` pulses in cycle 100 of the frame; `busy` falls the next cycle.
- PARITY=2, write 0x07 → parity bit 1; PARITY=1, write 0x07 → parity bit 0; frame length 110 cycles.
- `en`=0, 17 writes at FIFO_DEPTH=16 → `full`=1, `level`=16, `overflow`=1. Then set `en`=1 → 16 frames are sent and the 17th word never appears.
- Two writes back-to-back, DIV=10, 8N1 → 200 contiguous cycles of `busy` with no high idle gap between the two frames' stop and start bits; two `done` pulses.
- Assert `rst` at cycle 35 of a frame with 3 words queued → `tx`=1 and `level`=0 immediately; no further activity until new writes.
- With `UART_TX_BREAK_EN` defined, `brk`=1 while idle with a word queued → `tx`=0 and no frame starts. Release `brk` → the frame starts 1 cycle later.
